// File: rtl/jt12_lfo.sv
// jt12_lfo: LFO phase counter stepped once per slot cycle, plus registered per-slot AM attenuation
module jt12_lfo #(
  parameter int DIV_W = 7,
  parameter int LFO_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             zero,
  input  logic             lfo_en,
  input  logic [2:0]       lfo_freq,
  input  logic             amsen_I,
  input  logic [1:0]       ams_I,
  output logic [LFO_W-1:0] lfo_mod,
  output logic             lfo_step,
  output logic [6:0]       am_II
);
  logic [DIV_W-1:0] div, last;
  logic [5:0]       am_tri;
  logic [6:0]       am_full, am_scaled;
  // last = zero pulses per step minus one; >= keeps a mid-count rate change from running away
  always_comb begin
    case (lfo_freq)
      3'd0:    last = DIV_W'(107);
      3'd1:    last = DIV_W'(76);
      3'd2:    last = DIV_W'(70);
      3'd3:    last = DIV_W'(66);
      3'd4:    last = DIV_W'(61);
      3'd5:    last = DIV_W'(43);
      3'd6:    last = DIV_W'(7);
      default: last = DIV_W'(4);
    endcase
  end
  always_comb begin
    am_tri    = lfo_mod[6] ? lfo_mod[5:0] : ~lfo_mod[5:0];
    am_full   = {am_tri, 1'b0};
    am_scaled = ams_I == 2'd3 ? am_full :
                ams_I == 2'd2 ? {1'b0, am_full[6:1]} :
                ams_I == 2'd1 ? {3'b0, am_full[6:3]} : 7'd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div      <= '0;
      lfo_mod  <= '0;
      lfo_step <= 1'b0;
      am_II    <= '0;
    end else if (clk_en) begin
      lfo_step <= 1'b0;
      am_II    <= amsen_I ? am_scaled : 7'd0;
      if (!lfo_en) begin
        div     <= '0;
        lfo_mod <= '0;
      end else if (zero) begin
        if (div >= last) begin
          div      <= '0;
          lfo_mod  <= lfo_mod + 1'b1;
          lfo_step <= 1'b1;
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_jt12_lfo.sv
// tb_jt12_lfo: scoreboard bench; steps checked by zero-pulse index and value, AM checked one clk_en later
module tb_jt12_lfo;
  localparam int ZGAP = 24;
  logic       clk = 1'b0, rst, clk_en, zero, lfo_en, amsen_I, am_req, req_d;
  logic [2:0] lfo_freq;
  logic [1:0] ams_I;
  logic [6:0] lfo_mod, am_II;
  logic       lfo_step;
  int errors = 0, checks = 0, zcnt = 0, stepcnt = 0;
  int step_zq[$];
  int step_mq[$];
  int am_q[$];

  jt12_lfo dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .zero(zero), .lfo_en(lfo_en),
    .lfo_freq(lfo_freq), .amsen_I(amsen_I), .ams_I(ams_I),
    .lfo_mod(lfo_mod), .lfo_step(lfo_step), .am_II(am_II)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) req_d <= am_req & clk_en;

  always @(negedge clk) begin
    if (lfo_step) begin
      stepcnt++;
      if (step_zq.size() == 0) begin
        chk("unexpected_step_at_zero", zcnt, -1);
      end else begin
        chk("step_zero_index", zcnt, step_zq.pop_front());
        chk("step_lfo_mod", int'(lfo_mod), step_mq.pop_front());
      end
    end
    if (req_d) begin
      if (am_q.size() == 0) chk("am_no_expectation", int'(am_II), -1);
      else chk("am_II", int'(am_II), am_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zpulse();
    zero = 1'b1;
    zcnt++;
    tick();
    zero = 1'b0;
    repeat (ZGAP - 1) tick();
  endtask

  task automatic exp_step(input int n, input int m);
    step_zq.push_back(zcnt + n);
    step_mq.push_back(m);
  endtask

  task automatic am_check(input logic en, input logic [1:0] a, input int exp);
    amsen_I = en;
    ams_I   = a;
    am_req  = 1'b1;
    am_q.push_back(exp);
    tick();
    am_req  = 1'b0;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; clk_en = 1'b1; zero = 1'b0; lfo_en = 1'b1; lfo_freq = 3'd7;
    amsen_I = 1'b1; ams_I = 2'd3; am_req = 1'b0;
    repeat (6) begin
      zero = ~zero;
      tick();
      chk("rst_lfo_mod", int'(lfo_mod), 0);
      chk("rst_lfo_step", int'(lfo_step), 0);
      chk("rst_am_II", int'(am_II), 0);
    end
    zero = 1'b0;
    rst = 1'b1;
    tick();
    for (int k = 1; k <= 128; k++) begin
      exp_step(5, k % 128);
      repeat (5) zpulse();
      if (k == 1) begin
        am_check(1'b1, 2'd2, 62);
        am_check(1'b1, 2'd1, 15);
      end
      if (k == 64) begin
        am_check(1'b1, 2'd3, 0);
        clk_en = 1'b0; lfo_en = 1'b0; zero = 1'b1; lfo_freq = 3'd0;
        repeat (3) tick();
        chk("hold_lfo_mod", int'(lfo_mod), 64);
        chk("hold_lfo_step", int'(lfo_step), 0);
        clk_en = 1'b1; lfo_en = 1'b1; zero = 1'b0; lfo_freq = 3'd7;
      end
      if (k == 127) begin
        am_check(1'b1, 2'd3, 126);
        am_check(1'b0, 2'd3, 0);
      end
    end
    chk("wrap_lfo_mod", int'(lfo_mod), 0);
    chk("wrap_step_count", stepcnt, 128);
    am_check(1'b1, 2'd3, 126);
    am_check(1'b1, 2'd2, 63);
    am_check(1'b1, 2'd1, 15);
    am_check(1'b1, 2'd0, 0);
    lfo_freq = 3'd0;
    exp_step(108, 1);
    repeat (107) zpulse();
    chk("f0_no_step_at_107", int'(lfo_mod), 0);
    zpulse();
    chk("f0_step_at_108", int'(lfo_mod), 1);
    lfo_freq = 3'd7;
    for (int m = 2; m <= 37; m++) begin
      exp_step(5, m);
      repeat (5) zpulse();
    end
    chk("run_to_37", int'(lfo_mod), 37);
    lfo_en = 1'b0;
    zero = 1'b1;
    tick();
    zero = 1'b0;
    lfo_en = 1'b1;
    tick();
    chk("disable_clears", int'(lfo_mod), 0);
    lfo_freq = 3'd6;
    exp_step(8, 1);
    repeat (7) zpulse();
    chk("f6_no_step_at_7", int'(lfo_mod), 0);
    zpulse();
    lfo_freq = 3'd0;
    repeat (50) zpulse();
    chk("div50_no_step", int'(lfo_mod), 1);
    lfo_freq = 3'd7;
    exp_step(1, 2);
    zpulse();
    exp_step(5, 3);
    repeat (5) zpulse();
    exp_step(5, 4);
    repeat (5) zpulse();
    chk("rate_change_lfo_mod", int'(lfo_mod), 4);
    repeat (4) tick();
    chk("steps_pending", step_zq.size(), 0);
    chk("am_pending", am_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
